enum_state_sequencer: RTL and testbench

//  Upstream producer of the 2-bit state enum consumed by the enum %p formatting stage.

---
 rtl/enum_fmt_pkg.sv | 22 ++
 rtl/busy_down_counter.sv | 30 +++
 rtl/enum_state_sequencer.sv | 112 +++++++++++
 tb/tb_enum_state_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/enum_fmt_pkg.sv
// Shared state encoding for the sequencer and the downstream formatting stage.
// Also holds the helper that renders a raw 2-bit state the way %p prints it.
package enum_fmt_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_BUSY = 2'b01,
    STATE_DONE = 2'b10
  } my_enum_t;

  localparam string FMT_P = "%p";
  localparam logic [1:0] ILLEGAL_ENC = 2'b11;

  // In-enum values render as their name; the illegal encoding has no name, so %p falls back to the number.
  function automatic string fmt_state(input logic [1:0] raw);
    my_enum_t e;
    if (raw == ILLEGAL_ENC) return $sformatf("%0d", raw);
    e = my_enum_t'(raw);
    return e.name();
  endfunction

endpackage

// File: rtl/busy_down_counter.sv
// Loadable down-counter that sets the length of the BUSY phase.
// Priority: clear > load > decrement; it never decrements below zero.
module busy_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/enum_state_sequencer.sv
// IDLE->BUSY->DONE sequencer producing the 2-bit state enum, with a force path,
// a wrapping transition counter and a registered %p-style string of the state.
module enum_state_sequencer
  import enum_fmt_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TRANS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   busy_len_i,
  input  logic               ack_i,
  input  logic               force_i,
  input  logic [1:0]         force_val_i,
  output logic [1:0]         state_o,
  output logic               done_pulse_o,
  output logic               illegal_o,
  output logic [TRANS_W-1:0] trans_cnt_o,
  output logic [7:0]         str_len_o
);

  logic [1:0]       next_state;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_clear;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_val;
  logic             changed;
  string            state_str;
  string            next_str;

  busy_down_counter #(.CNT_W(CNT_W)) u_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .clear    (cnt_clear),
    .cnt      (cnt_val),
    .last     (cnt_last)
  );

  // Handshake: start_i is a request honoured only in IDLE (busy_len_i sampled with it);
  // ack_i is the consumer's accept, honoured only in DONE, including its entry cycle.
  always_comb begin
    next_state   = state_o;
    cnt_load     = 1'b0;
    cnt_load_val = busy_len_i;
    cnt_en       = 1'b0;
    cnt_clear    = 1'b0;
    if (force_i) begin
      next_state = force_val_i;
      if (force_val_i == STATE_BUSY) begin
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(1);
      end else begin
        cnt_clear = 1'b1;
      end
    end else begin
      case (state_o)
        STATE_IDLE: begin
          if (start_i) begin
            next_state   = STATE_BUSY;
            cnt_load     = 1'b1;
            cnt_load_val = (busy_len_i == '0) ? CNT_W'(1) : busy_len_i;
          end
        end
        STATE_BUSY: begin
          cnt_en = 1'b1;
          // A zero count in BUSY is unreachable, but treating it like the last cycle avoids a lock-up.
          if (cnt_last || (cnt_val == '0)) next_state = STATE_DONE;
        end
        STATE_DONE: begin
          if (ack_i) next_state = STATE_IDLE;
        end
        default: begin
          next_state = STATE_IDLE;
          cnt_clear  = 1'b1;
        end
      endcase
    end
  end

  assign changed = (next_state != state_o);

  always_comb begin
    next_str = fmt_state(next_state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_o      <= STATE_IDLE;
      done_pulse_o <= 1'b0;
      illegal_o    <= 1'b0;
      trans_cnt_o  <= '0;
      state_str    <= "";
    end else begin
      state_o      <= next_state;
      done_pulse_o <= (next_state == STATE_DONE) && (state_o != STATE_DONE);
      illegal_o    <= (next_state == ILLEGAL_ENC);
      if (changed) begin
        trans_cnt_o <= trans_cnt_o + TRANS_W'(1);
        state_str   <= next_str;
      end
    end
  end

  assign str_len_o = 8'(state_str.len());

endmodule

// File: tb/tb_enum_state_sequencer.sv
// Bench for enum_state_sequencer: directed vector table, async reset mid-BUSY,
// and randomized traffic against a behavioural model (built with TRANS_W=4 to reach the wrap quickly).
module tb_enum_state_sequencer;

  localparam int CW = 8;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [CW-1:0] busy_len_i;
  logic          ack_i;
  logic          force_i;
  logic [1:0]    force_val_i;
  logic [1:0]    state_o;
  logic          done_pulse_o;
  logic          illegal_o;
  logic [TW-1:0] trans_cnt_o;
  logic [7:0]    str_len_o;

  int checks   = 0;
  int failures = 0;

  enum_state_sequencer #(.CNT_W(CW), .TRANS_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_len_i   (busy_len_i),
    .ack_i        (ack_i),
    .force_i      (force_i),
    .force_val_i  (force_val_i),
    .state_o      (state_o),
    .done_pulse_o (done_pulse_o),
    .illegal_o    (illegal_o),
    .trans_cnt_o  (trans_cnt_o),
    .str_len_o    (str_len_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input int l, input int a, input int f, input int fv);
    start_i     = s[0];
    busy_len_i  = CW'(l);
    ack_i       = a[0];
    force_i     = f[0];
    force_val_i = fv[1:0];
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input int ep, input int ei, input int ec, input int el);
    chk({tag, ".state"},   16'(state_o),      16'(es));
    chk({tag, ".pulse"},   16'(done_pulse_o), 16'(ep));
    chk({tag, ".illegal"}, 16'(illegal_o),    16'(ei));
    chk({tag, ".trans"},   16'(trans_cnt_o),  16'(ec));
    chk({tag, ".strlen"},  16'(str_len_o),    16'(el));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int s, l, a, f, fv;
    int e_state, e_pulse, e_ill, e_cnt, e_len;
  } vec_t;

  function automatic vec_t mk(int s, int l, int a, int f, int fv, int es, int ep, int ei, int ec, int el);
    vec_t v;
    v.s = s; v.l = l; v.a = a; v.f = f; v.fv = fv;
    v.e_state = es; v.e_pulse = ep; v.e_ill = ei; v.e_cnt = ec; v.e_len = el;
    return v;
  endfunction

  vec_t vecs[23];

  // ---------------- reference model ----------------
  int m_state, m_left, m_cnt, m_len, m_pulse, m_ill;
  logic [15:0] exp_q[$];

  function automatic int name_len(int s);
    string nm;
    case (s)
      0:       nm = "STATE_IDLE";
      1:       nm = "STATE_BUSY";
      2:       nm = "STATE_DONE";
      default: nm = "3";
    endcase
    return nm.len();
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_cnt = 0; m_len = 0; m_pulse = 0; m_ill = 0;
  endtask

  task automatic model_step(input int s, input int l, input int a, input int f, input int fv);
    int nxt;
    nxt = m_state;
    if (f != 0) begin
      nxt    = fv;
      m_left = (fv == 1) ? 1 : 0;
    end else if (m_state == 3) begin
      nxt = 0;
    end else if (m_state == 0 && s != 0) begin
      nxt    = 1;
      m_left = (l == 0) ? 1 : l;
    end else if (m_state == 1) begin
      m_left--;
      if (m_left == 0) nxt = 2;
    end else if (m_state == 2 && a != 0) begin
      nxt = 0;
    end
    m_pulse = (nxt == 2 && m_state != 2) ? 1 : 0;
    m_ill   = (nxt == 3) ? 1 : 0;
    if (nxt != m_state) begin
      m_cnt = (m_cnt + 1) % (1 << TW);
      m_len = name_len(nxt);
    end
    m_state = nxt;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] e;
    logic [15:0] a;
    int s, l, ak, f, fv;

    vecs[0]  = mk(1, 3, 0, 0, 0, 1, 0, 0,  1, 10);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 10);
    vecs[2]  = mk(1, 0, 0, 0, 0, 1, 0, 0,  1, 10);
    vecs[3]  = mk(0, 0, 0, 0, 0, 2, 1, 0,  2, 10);
    vecs[4]  = mk(1, 0, 0, 0, 0, 2, 0, 0,  2, 10);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0,  3, 10);
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0,  3, 10);
    vecs[7]  = mk(1, 0, 1, 0, 0, 1, 0, 0,  4, 10);
    vecs[8]  = mk(0, 0, 1, 0, 0, 2, 1, 0,  5, 10);
    vecs[9]  = mk(0, 0, 1, 0, 0, 0, 0, 0,  6, 10);
    vecs[10] = mk(1, 5, 0, 0, 0, 1, 0, 0,  7, 10);
    vecs[11] = mk(0, 0, 0, 1, 3, 3, 0, 1,  8, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 0,  9, 10);
    vecs[13] = mk(0, 0, 0, 1, 0, 0, 0, 0,  9, 10);
    vecs[14] = mk(0, 0, 0, 1, 1, 1, 0, 0, 10, 10);
    vecs[15] = mk(0, 0, 0, 0, 0, 2, 1, 0, 11, 10);
    vecs[16] = mk(0, 0, 0, 1, 2, 2, 0, 0, 11, 10);
    vecs[17] = mk(0, 0, 0, 1, 3, 3, 0, 1, 12, 1);
    vecs[18] = mk(0, 0, 0, 1, 3, 3, 0, 1, 12, 1);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 13, 10);
    vecs[20] = mk(1, 1, 0, 0, 0, 1, 0, 0, 14, 10);
    vecs[21] = mk(0, 0, 0, 0, 0, 2, 1, 0, 15, 10);
    vecs[22] = mk(0, 0, 1, 0, 0, 0, 0, 0,  0, 10);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_all("idle_hold", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].l, vecs[i].a, vecs[i].f, vecs[i].fv);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_pulse, vecs[i].e_ill,
              vecs[i].e_cnt, vecs[i].e_len);
    end

    // Asynchronous reset in the middle of a long BUSY phase.
    drive(1, 10, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    step();
    chk("pre_reset.state", 16'(state_o), 16'(1));
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("post_reset", 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 1) == 1) ? 1 : 0;
      l  = $urandom_range(0, 6);
      ak = ($urandom_range(0, 2) == 0) ? 1 : 0;
      f  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      fv = $urandom_range(0, 3);
      drive(s, l, ak, f, fv);
      model_step(s, l, ak, f, fv);
      exp_q.push_back({2'(m_state), 1'(m_pulse), 1'(m_ill), 4'(m_cnt), 8'(m_len)});
      step();
      e = exp_q.pop_front();
      a = {state_o, done_pulse_o, illegal_o, trans_cnt_o, str_len_o};
      chk($sformatf("rand%0d", n), a, e);
    end
    chk("exp_q_empty", 16'(exp_q.size()), 16'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
